// File: rtl/exe_mem_pipe_reg.sv
// EX->MEM pipeline register chain.
// STAGES slots sit between the ALU and the data-memory stage. Each slot
// carries a valid bit plus the control, rd, ALU result and store data
// fields. The chain advances on the falling clock edge while the memory
// system reports a hit. Flush turns every slot into a bubble, and the
// per-slot destination-register match flags feed the hazard/forwarding unit.
module exe_mem_pipe_reg #(
  parameter int DATA_W       = 32,
  parameter int CTRL_W       = 9,
  parameter int REG_W        = 5,
  parameter int STAGES       = 1,
  parameter int REGWRITE_BIT = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_hit,
  input  logic              i_flush,
  input  logic              i_in_valid,
  input  logic [REG_W-1:0]  i_rd,
  input  logic [DATA_W-1:0] i_alu_result,
  input  logic [DATA_W-1:0] i_read_data2,
  input  logic [CTRL_W-1:0] i_control_sig,
  input  logic [REG_W-1:0]  i_src_rs,
  input  logic [REG_W-1:0]  i_src_rt,
  output logic              o_out_valid,
  output logic [CTRL_W-1:0] o_control_sig_out,
  output logic [REG_W-1:0]  o_rd_out,
  output logic [DATA_W-1:0] o_alu_result_out,
  output logic [DATA_W-1:0] o_read_data2_out,
  output logic [STAGES-1:0] o_rs_match,
  output logic [STAGES-1:0] o_rt_match
);

  // Chains longer than four slots, or empty chains, are not supported.
  if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
    $error("exe_mem_pipe_reg: STAGES must be in 1..4");
  end

  // Slot state; index 0 is the newest slot, STAGES-1 drives the outputs.
  logic [STAGES-1:0] r_valid;
  logic [CTRL_W-1:0] r_ctrl [STAGES];
  logic [REG_W-1:0]  r_rd   [STAGES];
  logic [DATA_W-1:0] r_alu  [STAGES];
  logic [DATA_W-1:0] r_rd2  [STAGES];

  logic [STAGES-1:0] w_rs_match;
  logic [STAGES-1:0] w_rt_match;

  // A slot matches a source register only if it holds a real instruction
  // that writes back to that register. Register 0 is hard-wired and never matches.
  function automatic logic f_match(
    input logic             valid,
    input logic             reg_write,
    input logic [REG_W-1:0] slot_rd,
    input logic [REG_W-1:0] src
  );
    return valid & reg_write & (slot_rd == src) & (src != '0);
  endfunction

  // Slot chain: async clear, then flush > hold (no hit) > advance on falling clk.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
      for (int k = 0; k < STAGES; k++) begin
        r_ctrl[k] <= '0;
        r_rd[k]   <= '0;
        r_alu[k]  <= '0;
        r_rd2[k]  <= '0;
      end
    end else if (i_flush) begin
      // Flush wins even over a miss; the inputs on this edge are dropped.
      r_valid <= '0;
      for (int k = 0; k < STAGES; k++) begin
        r_ctrl[k] <= '0;
        r_rd[k]   <= '0;
        r_alu[k]  <= '0;
        r_rd2[k]  <= '0;
      end
    end else if (i_hit) begin
      // A bubble enters with every field zeroed, so valid=0 always implies ctrl=0.
      r_valid[0] <= i_in_valid;
      r_ctrl[0]  <= i_in_valid ? i_control_sig : '0;
      r_rd[0]    <= i_in_valid ? i_rd          : '0;
      r_alu[0]   <= i_in_valid ? i_alu_result  : '0;
      r_rd2[0]   <= i_in_valid ? i_read_data2  : '0;
      for (int k = 1; k < STAGES; k++) begin
        r_valid[k] <= r_valid[k-1];
        r_ctrl[k]  <= r_ctrl[k-1];
        r_rd[k]    <= r_rd[k-1];
        r_alu[k]   <= r_alu[k-1];
        r_rd2[k]   <= r_rd2[k-1];
      end
    end else begin
      // Memory miss: every slot keeps its contents.
      r_valid <= r_valid;
      for (int k = 0; k < STAGES; k++) begin
        r_ctrl[k] <= r_ctrl[k];
        r_rd[k]   <= r_rd[k];
        r_alu[k]  <= r_alu[k];
        r_rd2[k]  <= r_rd2[k];
      end
    end
  end

  // Per-slot source-register match flags for the hazard/forwarding unit.
  always_comb begin
    w_rs_match = '0;
    w_rt_match = '0;
    for (int k = 0; k < STAGES; k++) begin
      w_rs_match[k] = f_match(r_valid[k], r_ctrl[k][REGWRITE_BIT], r_rd[k], i_src_rs);
      w_rt_match[k] = f_match(r_valid[k], r_ctrl[k][REGWRITE_BIT], r_rd[k], i_src_rt);
    end
  end

  assign o_out_valid       = r_valid[STAGES-1];
  assign o_control_sig_out = r_ctrl[STAGES-1];
  assign o_rd_out          = r_rd[STAGES-1];
  assign o_alu_result_out  = r_alu[STAGES-1];
  assign o_read_data2_out  = r_rd2[STAGES-1];
  assign o_rs_match        = w_rs_match;
  assign o_rt_match        = w_rt_match;

endmodule
